// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared types and constants for the min/max burst sequencer.
// DW and MAXN are fixed by the shared 4-bit comparator and the 3-bit len encoding.
package cmp_seq_ctrl_pkg;

    localparam int DW   = 4;
    localparam int MAXN = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_CMP_MAX = 3'd2,
        S_CMP_MIN = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t GT = 3'b001;
    localparam cmp_res_t EQ = 3'b010;
    localparam cmp_res_t LT = 3'b100;

    // len==0 encodes a full burst of MAXN samples
    function automatic logic [3:0] target_len(input logic [2:0] len);
        return (len == 3'd0) ? 4'(MAXN) : {1'b0, len};
    endfunction

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Control and sample-stream bundle between a requester and cmp_seq_ctrl.
interface cmp_seq_ctrl_if;
    import cmp_seq_ctrl_pkg::*;

    logic          start;
    logic [2:0]    len;
    logic          abort;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] max_out;
    logic [DW-1:0] min_out;
    logic [2:0]    max_idx;
    logic [2:0]    min_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, len, abort, din, din_valid,
        input  din_ready, max_out, min_out, max_idx, min_idx, busy, done
    );

    modport slave (
        input  start, len, abort, din, din_valid,
        output din_ready, max_out, min_out, max_idx, min_idx, busy, done
    );

endinterface

// File: rtl/cmp_seq_ctrl_compare.sv
// Shared 4-bit magnitude comparator with one-hot GT/EQ/LT result.
module compare
    import cmp_seq_ctrl_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output cmp_res_t      res_o
);

    always_comb begin
        res_o = EQ;
        if (a_i > b_i)
            res_o = GT;
        else if (a_i < b_i)
            res_o = LT;
    end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Burst min/max finder: accepts len samples and reports the extremes and their
// first positions, sharing one comparator between the max and min checks.
module cmp_seq_ctrl
    import cmp_seq_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cmp_seq_ctrl_if.slave bus
);

    state_e        state_q;
    logic [3:0]    tgt_q;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic [DW-1:0] sample_q;
    logic [DW-1:0] max_q;
    logic [DW-1:0] min_q;
    logic [DW-1:0] min_d;
    logic [2:0]    max_idx_q;
    logic [2:0]    min_idx_q;
    logic [2:0]    min_idx_d;
    logic [DW-1:0] cmp_a_q;
    logic [DW-1:0] cmp_b_q;
    cmp_res_t      cmp_res;
    logic [DW-1:0] max_out_q;
    logic [DW-1:0] min_out_q;
    logic [2:0]    max_idx_out_q;
    logic [2:0]    min_idx_out_q;
    logic          din_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          hs;

    compare u_compare (
        .a_i   (cmp_a_q),
        .b_i   (cmp_b_q),
        .res_o (cmp_res)
    );

    assign hs = bus.din_valid & din_ready_q;

    // Strict LT only, so ties keep the earlier index
    always_comb begin
        cnt_d     = cnt_q + 4'd1;
        min_d     = min_q;
        min_idx_d = min_idx_q;
        if (cmp_res == LT) begin
            min_d     = sample_q;
            min_idx_d = cnt_q[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            tgt_q         <= '0;
            cnt_q         <= '0;
            sample_q      <= '0;
            max_q         <= '0;
            min_q         <= '0;
            max_idx_q     <= '0;
            min_idx_q     <= '0;
            cmp_a_q       <= '0;
            cmp_b_q       <= '0;
            max_out_q     <= '0;
            min_out_q     <= '0;
            max_idx_out_q <= '0;
            min_idx_out_q <= '0;
            din_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && bus.abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                din_ready_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            tgt_q       <= target_len(bus.len);
                            cnt_q       <= '0;
                            state_q     <= S_WAIT;
                            busy_q      <= 1'b1;
                            din_ready_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (hs) begin
                            sample_q <= bus.din;
                            if (cnt_q == 4'd0) begin
                                max_q     <= bus.din;
                                min_q     <= bus.din;
                                max_idx_q <= '0;
                                min_idx_q <= '0;
                                cnt_q     <= cnt_d;
                                if (cnt_d == tgt_q) begin
                                    state_q       <= S_DONE;
                                    din_ready_q   <= 1'b0;
                                    done_q        <= 1'b1;
                                    max_out_q     <= bus.din;
                                    min_out_q     <= bus.din;
                                    max_idx_out_q <= '0;
                                    min_idx_out_q <= '0;
                                end
                            end else begin
                                // A/B registered here so the comparator is stable in CMP_MAX
                                cmp_a_q     <= bus.din;
                                cmp_b_q     <= max_q;
                                state_q     <= S_CMP_MAX;
                                din_ready_q <= 1'b0;
                            end
                        end
                    end
                    S_CMP_MAX: begin
                        if (cmp_res == GT) begin
                            max_q     <= sample_q;
                            max_idx_q <= cnt_q[2:0];
                        end
                        cmp_a_q <= sample_q;
                        cmp_b_q <= min_q;
                        state_q <= S_CMP_MIN;
                    end
                    S_CMP_MIN: begin
                        min_q     <= min_d;
                        min_idx_q <= min_idx_d;
                        cnt_q     <= cnt_d;
                        if (cnt_d == tgt_q) begin
                            state_q       <= S_DONE;
                            done_q        <= 1'b1;
                            max_out_q     <= max_q;
                            max_idx_out_q <= max_idx_q;
                            min_out_q     <= min_d;
                            min_idx_out_q <= min_idx_d;
                        end else begin
                            state_q     <= S_WAIT;
                            din_ready_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        din_ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.din_ready = din_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.max_out   = max_out_q;
    assign bus.min_out   = min_out_q;
    assign bus.max_idx   = max_idx_out_q;
    assign bus.min_idx   = min_idx_out_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Directed vector bench for cmp_seq_ctrl: burst results, latency, abort and reset.
module tb_cmp_seq_ctrl;

    logic clk = 1'b0;
    logic rst;

    cmp_seq_ctrl_if vif ();

    cmp_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  len;
        logic [31:0] smp;   // nibble i = sample i
        int          n;
        int          emax;
        int          emin;
        int          emaxi;
        int          emini;
    } vec_t;

    vec_t vecs [7];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts a burst and streams samples with din_valid held high until done,
    // or until stop_k samples have been accepted. With poke set, start is
    // re-asserted (len=1) while busy, which must have no effect.
    task automatic run_burst(input vec_t v, input int stop_k, input bit poke,
                             output int cyc, output int k, output bit got_done);
        int kk;
        bit rdy;
        @(negedge clk);
        vif.start     = 1'b1;
        vif.len       = v.len;
        vif.din_valid = 1'b0;
        cyc = 0;
        k = 0;
        got_done = 1'b0;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        vif.start     = 1'b0;
        vif.din_valid = 1'b1;
        while (!got_done && k < stop_k && cyc < 60) begin
            kk = (k < 8) ? k : 7;
            vif.din = v.smp[4*kk +: 4];
            if (poke && cyc >= 2) begin
                vif.start = 1'b1;
                vif.len   = 3'd1;
            end
            rdy = vif.din_ready;
            @(posedge clk);
            cyc++;
            if (rdy) k++;
            @(negedge clk);
            if (vif.done) got_done = 1'b1;
        end
        vif.start     = 1'b0;
        vif.din_valid = 1'b0;
    endtask

    task automatic chk_outputs(input string tag, input int mx, input int mn,
                               input int mxi, input int mni);
        chk({tag, " max_out"}, int'(vif.max_out), mx);
        chk({tag, " min_out"}, int'(vif.min_out), mn);
        chk({tag, " max_idx"}, int'(vif.max_idx), mxi);
        chk({tag, " min_idx"}, int'(vif.min_idx), mni);
    endtask

    task automatic full_burst(input vec_t v, input bit poke, input string tag);
        int cyc, k;
        bit got;
        run_burst(v, 99, poke, cyc, k, got);
        chk({tag, " done seen"}, int'(got), 1);
        chk({tag, " cycles"}, cyc, 2 + 3 * (v.n - 1));
        chk({tag, " accepted"}, k, v.n);
        chk_outputs(tag, v.emax, v.emin, v.emaxi, v.emini);
        @(negedge clk);
        chk({tag, " done width"}, int'(vif.done), 0);
        chk({tag, " idle after"}, int'(vif.busy), 0);
    endtask

    initial begin
        int  cyc, k;
        bit  got, seen_done;

        vecs[0] = '{3'd4, 32'h0000_9193, 4, 9, 1, 1, 2};
        vecs[1] = '{3'd1, 32'h0000_0007, 1, 7, 7, 0, 0};
        vecs[2] = '{3'd0, 32'hECA8_6420, 8, 14, 0, 7, 0};
        vecs[3] = '{3'd3, 32'h0000_0555, 3, 5, 5, 0, 0};
        vecs[4] = '{3'd5, 32'h000F_2F28, 5, 15, 2, 2, 1};
        vecs[5] = '{3'd2, 32'h0000_00F0, 2, 15, 0, 1, 0};
        vecs[6] = '{3'd7, 32'h00AB_CDEF, 7, 15, 0, 0, 6};

        rst           = 1'b1;
        vif.start     = 1'b0;
        vif.len       = 3'd0;
        vif.abort     = 1'b0;
        vif.din       = '0;
        vif.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", int'(vif.busy), 0);
        chk("reset done", int'(vif.done), 0);
        chk("reset din_ready", int'(vif.din_ready), 0);
        chk_outputs("reset", 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            full_burst(vecs[i], (i == 2 || i == 4), $sformatf("vec%0d", i));

        // Abort after two of four samples
        run_burst(vecs[0], 2, 1'b0, cyc, k, got);
        chk("abort pre accepted", k, 2);
        chk("abort pre busy", int'(vif.busy), 1);
        vif.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vif.abort = 1'b0;
        chk("abort busy", int'(vif.busy), 0);
        chk("abort din_ready", int'(vif.din_ready), 0);
        seen_done = vif.done;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen_done |= vif.done;
        end
        chk("abort no done", int'(seen_done), 0);
        chk_outputs("abort hold", 15, 0, 0, 6);
        full_burst(vecs[0], 1'b0, "after abort");

        // Reset while in CMP_MAX
        run_burst(vecs[4], 2, 1'b0, cyc, k, got);
        chk("rst pre busy", int'(vif.busy), 1);
        chk("rst pre din_ready", int'(vif.din_ready), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst async busy", int'(vif.busy), 0);
        chk_outputs("rst async", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen_done |= vif.done | vif.busy;
        end
        chk("rst no done/busy", int'(seen_done), 0);
        full_burst(vecs[1], 1'b0, "after rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_seq_ctrl.md
CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

Interface
REQ-001 Parameter: DW, 4, sample width; fixed at 4 to match the shared 4-bit comparator.
REQ-002 Parameter: MAXN, 8, maximum samples per burst; the len encoding below relies on this value.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  burst start request; sampled only in IDLE.
REQ-006 Port: len  input  3  burst length latched on start; 1..7 literal, 0 means 8.
REQ-007 Port: abort  input  1  synchronous abort; returns to IDLE without done.
REQ-008 Port: din  input  4  sample data.
REQ-009 Port: din_valid  input  1  sample valid.
REQ-010 Port: din_ready  output  1  sample accepted when din_valid and din_ready are both high on a rising edge.
REQ-011 Port: max_out  output  4  largest sample of the last completed burst.
REQ-012 Port: min_out  output  4  smallest sample of the last completed burst.
REQ-013 Port: max_idx  output  3  burst position (0-based) of max_out.
REQ-014 Port: min_idx  output  3  burst position (0-based) of min_out.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: done  output  1  one-cycle pulse when results are valid.

Function
REQ-017 FSM states: IDLE, WAIT, CMP_MAX, CMP_MIN, DONE.
REQ-018 IDLE: on start=1, latch len, clear count and go to WAIT; otherwise stay in IDLE.
REQ-019 WAIT: din_ready=1. On handshake, register din as the current sample.
REQ-020 WAIT, first sample (count=0): load max, min and the current sample; set both indices to 0; increment count; go to DONE if count+1 equals the target length, otherwise stay in WAIT.
REQ-021 WAIT, later sample: go to CMP_MAX; din_ready is 0 in every state except WAIT.
REQ-022 Comparator sharing: exactly one comparator instance, time-multiplexed; one-hot result 001 means A>B, 010 means A=B, 100 means A<B.
REQ-023 CMP_MAX: drive A=sample and B=running max; if the result is 001, replace max and set max_idx=count; then go to CMP_MIN.
REQ-024 CMP_MIN: drive A=sample and B=running min; if the result is 100, replace min and set min_idx=count; increment count; go to DONE if count equals the target, otherwise go to WAIT.
REQ-025 Ties never update: on equal values, the earliest index is retained.
REQ-026 DONE: done=1 for exactly one cycle; results go to the outputs in the same cycle; next state is IDLE.
REQ-027 Output hold: max_out, min_out, max_idx and min_idx hold their values until the next DONE; internal running registers are not visible on the outputs.
REQ-028 Throughput: first sample costs 1 cycle; each later sample costs 3 cycles (WAIT, CMP_MAX, CMP_MIN) with din_valid held high.
REQ-029 Latency: done is asserted on the cycle after the CMP_MIN of the last sample, or after the handshake when len=1.
REQ-030 start while busy: ignored, with no effect on the current burst.
REQ-031 abort: takes priority in any state except IDLE; go to IDLE next cycle, keep previous outputs, no done pulse. An abort coinciding with a handshake discards the sample.
REQ-032 Simultaneous abort and start: if the FSM is in IDLE, start is honoured; if busy, abort wins.
REQ-033 Counter: 4-bit count, compared against the target (len=0 maps to 8); count never wraps within a burst.

Reset
REQ-034 On rst=1, asynchronously: state=IDLE; din_ready, busy and done =0; max_out, min_out, max_idx and min_idx =0; count and running registers =0.
REQ-035 Reset mid-burst discards the burst, and no done pulse follows reset release.

Structure
REQ-036 Shared package holds: FSM state encoding; comparator result constants GT=3'b001, EQ=3'b010, LT=3'b100; MAXN.
REQ-037 The existing 4-bit comparator module `compare` is instantiated once as the sub-module, with its A/B inputs driven by a registered mux.
REQ-038 No other sub-modules.

Verification
REQ-039 len=4, samples 3,9,1,9 -> done after 11 cycles; max_out=9, max_idx=1, min_out=1, min_idx=2.
REQ-040 len=1, sample 7 -> done 1 cycle after the handshake; max=min=7, both indices 0.
REQ-041 len=0, samples 0..15 step 2 (0,2,...,14) -> 8 samples accepted; max_out=14, max_idx=7, min_out=0, min_idx=0.
REQ-042 len=3, samples 5,5,5 -> max_out=min_out=5, both indices 0 (tie rule).
REQ-043 abort after 2 of 4 samples -> IDLE next cycle, no done; prior outputs unchanged; a new start then completes normally.
REQ-044 rst pulsed mid CMP_MAX -> all outputs 0 immediately; start during busy ignored; din_ready 0 outside WAIT throughout.
